// File: rtl/redirect_ctrl.sv
// Control-flow redirect sequencer: arbitrates branch/jump/exception
// requests, pulses a redirect, then holds decode for a flush window.
module redirect_ctrl #(
    parameter int                     PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0]    TRAP_VECTOR  = 32'h0000_0100,
    parameter int                     FLUSH_CYCLES = 2,
    parameter int                     CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 br_req,
    input  logic                 jmp_req,
    input  logic [PC_WIDTH-1:0]  target,
    input  logic                 exc_req,
    input  logic [PC_WIDTH-1:0]  req_pc,
    input  logic                 stall_in,
    output logic                 req_ready,
    output logic                 branch,
    output logic                 jump,
    output logic                 exception,
    output logic [PC_WIDTH-1:0]  pc_override,
    output logic                 stall,
    output logic                 id_stall,
    output logic                 flush,
    output logic [PC_WIDTH-1:0]  epc,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] redirect_count
);

    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REDIR = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    localparam logic [1:0] K_BR  = 2'd0;
    localparam logic [1:0] K_JMP = 2'd1;
    localparam logic [1:0] K_EXC = 2'd2;

    logic [1:0]           state;
    logic [1:0]           kind;
    logic [FW-1:0]        fcnt;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 any_req;
    logic                 take_exc;

    assign any_req  = exc_req | jmp_req | br_req;
    // A misaligned branch/jump target becomes an exception
    assign take_exc = exc_req | (target[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            kind        <= K_BR;
            fcnt        <= '0;
            cnt         <= '0;
            pc_override <= '0;
            epc         <= '0;
        end else begin
            if (state == S_REDIR && cnt != '1)
                cnt <= cnt + 1'b1;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        state <= S_REDIR;
                        if (take_exc) begin
                            kind        <= K_EXC;
                            pc_override <= TRAP_VECTOR;
                            epc         <= req_pc;
                        end else begin
                            kind        <= jmp_req ? K_JMP : K_BR;
                            pc_override <= target;
                        end
                    end
                end
                S_REDIR, S_FLUSH: begin
                    if (exc_req) begin
                        // Exception on top of an exception is fatal
                        if (kind == K_EXC) begin
                            state <= S_HALT;
                        end else begin
                            state       <= S_REDIR;
                            kind        <= K_EXC;
                            pc_override <= TRAP_VECTOR;
                            epc         <= req_pc;
                        end
                    end else if (state == S_REDIR) begin
                        state <= S_FLUSH;
                        fcnt  <= FW'(FLUSH_CYCLES - 1);
                    end else if (fcnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        fcnt <= fcnt - 1'b1;
                    end
                end
                default: begin
                    state <= S_HALT;
                end
            endcase
        end
    end

    assign req_ready      = (state == S_IDLE);
    assign flush          = (state == S_REDIR);
    assign branch         = flush && (kind == K_BR);
    assign jump           = flush && (kind == K_JMP);
    assign exception      = flush && (kind == K_EXC);
    assign id_stall       = (state != S_IDLE);
    assign halted         = (state == S_HALT);
    assign stall          = stall_in | halted;
    assign redirect_count = cnt;

endmodule

// File: tb/tb_redirect_ctrl.sv
// Scoreboard bench for redirect_ctrl: a timeline model predicts every
// cycle's outputs and every redirect; a monitor pops and compares.
module tb_redirect_ctrl;

    localparam int          PW = 32;
    localparam logic [31:0] TV = 32'h0000_0100;
    localparam int          FC = 2;
    localparam int          CW = 3;

    logic          clk = 1'b0;
    logic          rst, br_req, jmp_req, exc_req, stall_in;
    logic [PW-1:0] target, req_pc;
    logic          req_ready, branch, jump, exception, stall;
    logic          id_stall, flush, halted;
    logic [PW-1:0] pc_override, epc;
    logic [CW-1:0] redirect_count;

    always #5 clk = ~clk;

    redirect_ctrl #(
        .PC_WIDTH    (PW),
        .TRAP_VECTOR (TV),
        .FLUSH_CYCLES(FC),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .br_req        (br_req),
        .jmp_req       (jmp_req),
        .target        (target),
        .exc_req       (exc_req),
        .req_pc        (req_pc),
        .stall_in      (stall_in),
        .req_ready     (req_ready),
        .branch        (branch),
        .jump          (jump),
        .exception     (exception),
        .pc_override   (pc_override),
        .stall         (stall),
        .id_stall      (id_stall),
        .flush         (flush),
        .epc           (epc),
        .halted        (halted),
        .redirect_count(redirect_count)
    );

    typedef struct packed {
        logic          br;
        logic          jp;
        logic          ex;
        logic          fl;
        logic          ids;
        logic          rdy;
        logic          hlt;
        logic          stl;
        logic [31:0]   epc;
        logic [CW-1:0] cnt;
    } st_t;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] pc;
    } rd_t;

    st_t sq[$];
    rd_t rq[$];
    int  total = 0;
    int  bad   = 0;

    // Model: mode 0=idle 1=busy 2=halted; busy lasts 1+FC cycles
    int          m_mode  = 0;
    int          m_left  = 0;
    bit          m_pulse = 0;
    logic [1:0]  m_kind  = 2'd0;
    logic [31:0] m_pc    = '0;
    logic [31:0] m_epc   = '0;
    int          m_cnt   = 0;

    task automatic start_redirect(input logic [1:0] k, input logic [31:0] pc);
        rd_t r;
        m_kind  = k;
        m_pc    = pc;
        m_mode  = 1;
        m_left  = 1 + FC;
        m_pulse = 1;
        r.kind  = k;
        r.pc    = pc;
        rq.push_back(r);
    endtask

    task automatic cyc(input logic r, input logic b, input logic j,
                       input logic e, input logic [31:0] t,
                       input logic [31:0] p, input logic s);
        st_t        x;
        bit         was_pulse;
        logic [1:0] lo;
        @(negedge clk);
        rst      = r;
        br_req   = b;
        jmp_req  = j;
        exc_req  = e;
        target   = t;
        req_pc   = p;
        stall_in = s;
        lo       = t[1:0];
        if (r) begin
            m_mode  = 0;
            m_left  = 0;
            m_pulse = 0;
            m_pc    = '0;
            m_epc   = '0;
            m_cnt   = 0;
            rq.delete();
        end else begin
            was_pulse = m_pulse;
            m_pulse   = 0;
            if (was_pulse && m_cnt < (1 << CW) - 1)
                m_cnt++;
            if (m_mode == 0) begin
                if (e || (lo != 2'b00 && (b || j))) begin
                    m_epc = p;
                    start_redirect(2'd2, TV);
                end else if (j) begin
                    start_redirect(2'd1, t);
                end else if (b) begin
                    start_redirect(2'd0, t);
                end
            end else if (m_mode == 1) begin
                if (e) begin
                    if (m_kind == 2'd2) begin
                        m_mode = 2;
                    end else begin
                        m_epc = p;
                        start_redirect(2'd2, TV);
                    end
                end else begin
                    m_left--;
                    if (m_left == 0)
                        m_mode = 0;
                end
            end
        end
        x.br  = m_pulse && m_kind == 2'd0;
        x.jp  = m_pulse && m_kind == 2'd1;
        x.ex  = m_pulse && m_kind == 2'd2;
        x.fl  = m_pulse;
        x.ids = (m_mode != 0);
        x.rdy = (m_mode == 0);
        x.hlt = (m_mode == 2);
        x.stl = s | (m_mode == 2);
        x.epc = m_epc;
        x.cnt = CW'(m_cnt);
        sq.push_back(x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    st_t        mon_e, mon_a;
    rd_t        mon_r;
    logic [1:0] mon_k;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sq.size() > 0) begin
                mon_e = sq.pop_front();
                mon_a = {branch, jump, exception, flush, id_stall,
                         req_ready, halted, stall, epc, redirect_count};
                total++;
                if (mon_a !== mon_e) begin
                    bad++;
                    $display("FAIL status @%0t: got %h want %h",
                             $time, mon_a, mon_e);
                end
                if (branch | jump | exception) begin
                    mon_k = exception ? 2'd2 : (jump ? 2'd1 : 2'd0);
                    total++;
                    if (rq.size() == 0) begin
                        bad++;
                        $display("FAIL redirect @%0t: unexpected pulse kind=%0d",
                                 $time, mon_k);
                    end else begin
                        mon_r = rq.pop_front();
                        if (mon_k !== mon_r.kind || pc_override !== mon_r.pc) begin
                            bad++;
                            $display("FAIL redirect @%0t: got kind=%0d pc=%h want kind=%0d pc=%h",
                                     $time, mon_k, pc_override, mon_r.kind, mon_r.pc);
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic        r, b, j, e, s;
        logic [31:0] t, p;
        rst      = 1'b1;
        br_req   = 1'b0;
        jmp_req  = 1'b0;
        exc_req  = 1'b0;
        stall_in = 1'b0;
        target   = '0;
        req_pc   = '0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        idle(1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 1'b0);
        idle(4);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 32'h80, 1'b0);
        idle(4);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h42, 32'h10, 1'b0);
        idle(4);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h1c, 1'b0);
        idle(1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h24, 1'b0);
        idle(4);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h30, 1'b0);
        idle(1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h34, 1'b0);
        idle(2);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'h44, 32'h38, 1'b1);
        idle(2);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        idle(2);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(0, 59) == 0);
            b = ($urandom_range(0, 3) == 0);
            j = ($urandom_range(0, 4) == 0);
            e = ($urandom_range(0, 9) == 0);
            t = $urandom;
            if ($urandom_range(0, 7) != 0)
                t[1:0] = 2'b00;
            p = $urandom;
            s = ($urandom_range(0, 3) == 0);
            cyc(r, b, j, e, t, p, s);
        end
        idle(5);
        @(negedge clk);
        total++;
        if (rq.size() != 0 || sq.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d/%0d queued want 0/0",
                     rq.size(), sq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/redirect_ctrl.md
Name: redirect_ctrl

Overview:
- Control-flow redirect sequencer; the producer side of the core's fetch-control interface (branch, jump, exception, stall, pc_override, id_stall).
- Takes resolved branch/jump/exception requests from the execute side, arbitrates them, and emits one-cycle redirect pulses with the override PC.
- Then holds a timed flush window so decode does not consume stale instructions from the IF/ID FIFO.
- Tracks exception PC and double faults, and counts redirects.

Parameters:
PC_WIDTH, 32, width of all PC/target buses
TRAP_VECTOR, 32'h0000_0100, override PC used for every exception redirect
FLUSH_CYCLES, 2, cycles spent in FLUSH after each redirect (>=1)
CNT_WIDTH, 16, width of saturating redirect counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
br_req  in  1  taken-branch request, valid when req_ready=1
jmp_req  in  1  jump request, valid when req_ready=1
target  in  PC_WIDTH  branch/jump target
exc_req  in  1  exception request, accepted in any non-HALT state
req_pc  in  PC_WIDTH  PC of the requesting instruction
stall_in  in  1  external stall, passed through
req_ready  out  1  1 only in IDLE
branch  out  1  one-cycle redirect pulse
jump  out  1  one-cycle redirect pulse
exception  out  1  one-cycle redirect pulse
pc_override  out  PC_WIDTH  redirect PC, registered
stall  out  1  fetch stall
id_stall  out  1  decode hold
flush  out  1  IF/ID flush pulse
epc  out  PC_WIDTH  captured exception PC
halted  out  1  double-fault indicator
redirect_count  out  CNT_WIDTH  saturating count of issued redirects

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE.
  - branch, jump, exception, flush, id_stall, halted = 0.
  - pc_override=0, epc=0, redirect_count=0, flush counter=0.
  - Reset overrides every state, including HALT and mid-FLUSH.
- States: IDLE, REDIRECT, FLUSH, HALT.
- IDLE:
  - Requests sampled at the edge. Priority: exc_req > jmp_req > br_req.
  - Any request moves to REDIRECT at the next edge.
  - Registers kind, pc_override and epc as set out below.
  - No request: stay in IDLE.
- Target alignment (branch/jump):
  - target[1:0]!=0 converts the request to an exception: kind=EXC, pc_override=TRAP_VECTOR, epc=req_pc.
- Exception kind:
  - pc_override=TRAP_VECTOR, epc=req_pc.
- Branch/jump kind:
  - pc_override=target; epc unchanged.
- REDIRECT (exactly 1 cycle):
  - Exactly one of branch/jump/exception=1, matching kind.
  - flush=1, id_stall=1.
  - Flush counter loaded with FLUSH_CYCLES-1.
  - redirect_count increments, saturating at all-ones.
  - Next state FLUSH.
- FLUSH:
  - id_stall=1; pulses 0; flush=0.
  - Counter decrements each cycle; at 0 go to IDLE next edge.
  - Window is exactly FLUSH_CYCLES cycles.
- exc_req while in REDIRECT or FLUSH:
  - If the current kind is branch/jump: preempt. Next state REDIRECT with kind=EXC, epc=req_pc; the flush window restarts.
  - If the current kind is EXC: double fault. Next state HALT; epc keeps the first exception's PC.
- br_req/jmp_req outside IDLE: ignored (req_ready=0); no state change.
- HALT:
  - halted=1, stall=1, id_stall=1, pulses 0, req_ready=0.
  - All requests ignored; exit only via rst.
- stall = stall_in | halted (combinational). stall_in does not freeze the FSM or the flush counter.
- req_ready = (state==IDLE), combinational.
- Latency: request at edge N → pulse high during cycle N+1 → IDLE again after N+1+FLUSH_CYCLES.

Test Plan:
- Reset, then br_req=1, target=0x40 for one cycle → next cycle branch=1, flush=1, pc_override=0x40; id_stall=1 for 3 cycles; req_ready returns 1 on cycle 4; redirect_count=1.
- br_req, jmp_req and exc_req together, req_pc=0x80 → only exception=1, pc_override=0x100, epc=0x80.
- jmp_req with target=0x42, req_pc=0x10 → exception=1 (jump=0), pc_override=0x100, epc=0x10.
- br_req with target 0x20, then exc_req (req_pc=0x24) during FLUSH → second REDIRECT with exception=1, epc=0x24; id_stall stays high 2 more cycles after it; redirect_count=2.
- exc_req at 0x30, then exc_req at 0x34 during FLUSH → halted=1, stall=1, epc=0x30; further requests ignored; rst clears halted and returns to IDLE.
- Force redirect_count to all-ones (CNT_WIDTH=2, 4 branches) → stays 3; stall_in=1 in IDLE → stall=1, FSM unaffected.
